// File: rtl/game_pkg.sv
// Shared types and constants for the guess-game controller and its LFSR.
package game_pkg;

    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned RESULT_W   = 6;
    localparam int unsigned GUESS_W    = DIGIT_W * NUM_DIGITS;

    localparam logic [2:0]  WIN_CODE  = 3'b100;
    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    typedef enum logic [2:0] {
        IDLE,
        GEN,
        ENTRY,
        CHECK1,
        CHECK2,
        JUDGE,
        WIN,
        LOSE
    } state_e;

    function automatic logic is_bcd(input logic [DIGIT_W-1:0] d);
        return d <= 4'd9;
    endfunction

endpackage

// File: rtl/guess_game_ctrl_lfsr16.sv
// Free-running 16-bit Fibonacci LFSR; exposes the low nibble as the digit candidate.
module lfsr16
    import game_pkg::*;
#(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    output logic [DIGIT_W-1:0] rnd
);

    logic [15:0] lfsr_q, lfsr_d;

    always_comb begin
        lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end

    always_ff @(posedge clk) begin
        if (rst) lfsr_q <= SEED;
        else     lfsr_q <= lfsr_d;
    end

    assign rnd = lfsr_q[DIGIT_W-1:0];

endmodule

// File: rtl/guess_game_ctrl.sv
// Drives the 3-digit guess checker: target generation, guess entry, attempt/win/lose tracking.
// Optional macro DUP_DIGIT_REJECT_EN adds dup_err and refuses guesses with repeated digits.
module guess_game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned MAX_TRIES = 8,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                new_game,
    input  logic [DIGIT_W-1:0]  digit_in,
    input  logic                digit_valid,
    input  logic                submit,
    input  logic [RESULT_W-1:0] check_result,
    output logic [GUESS_W-1:0]  input_number,
    output logic [GUESS_W-1:0]  target_number,
    output logic                start_check,
    output logic [RESULT_W-1:0] last_result,
    output logic [3:0]          tries_used,
    output logic                game_won,
    output logic                game_lost,
    output logic                busy
`ifdef DUP_DIGIT_REJECT_EN
   ,output logic                dup_err
`endif
);

    state_e                state_q, state_d;
    logic [GUESS_W-1:0]    target_q, target_d;
    logic [GUESS_W-1:0]    guess_q, guess_d;
    logic [1:0]            digit_cnt_q, digit_cnt_d;
    logic [1:0]            gen_cnt_q, gen_cnt_d;
    logic [RESULT_W-1:0]   last_q, last_d;
    logic [3:0]            tries_q, tries_d;
    logic [DIGIT_W-1:0]    cand;
    logic                  cand_ok;
    logic                  submit_ok;
`ifdef DUP_DIGIT_REJECT_EN
    logic                  dup_q, dup_d;
    logic                  guess_distinct;
`endif

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk (clk),
        .rst (rst),
        .rnd (cand)
    );

    // Only compare against slots already filled in this game
    always_comb begin
        cand_ok = is_bcd(cand)
                  && !(gen_cnt_q > 2'd0 && cand == target_q[11:8])
                  && !(gen_cnt_q > 2'd1 && cand == target_q[7:4]);
    end

    assign submit_ok = submit && !digit_valid && (digit_cnt_q == 2'd3);

`ifdef DUP_DIGIT_REJECT_EN
    assign guess_distinct = (guess_q[11:8] != guess_q[7:4])
                         && (guess_q[11:8] != guess_q[3:0])
                         && (guess_q[7:4]  != guess_q[3:0]);
`endif

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        guess_d     = guess_q;
        digit_cnt_d = digit_cnt_q;
        gen_cnt_d   = gen_cnt_q;
        last_d      = last_q;
        tries_d     = tries_q;
`ifdef DUP_DIGIT_REJECT_EN
        dup_d       = 1'b0;
`endif
        if (new_game) begin
            state_d     = GEN;
            tries_d     = '0;
            last_d      = '0;
            guess_d     = '0;
            digit_cnt_d = '0;
            gen_cnt_d   = '0;
        end else begin
            case (state_q)
                GEN: begin
                    if (cand_ok) begin
                        case (gen_cnt_q)
                            2'd0:    target_d[11:8] = cand;
                            2'd1:    target_d[7:4]  = cand;
                            default: target_d[3:0]  = cand;
                        endcase
                        gen_cnt_d = gen_cnt_q + 2'd1;
                        if (gen_cnt_q == 2'd2) state_d = ENTRY;
                    end
                end
                ENTRY: begin
                    if (digit_valid && is_bcd(digit_in)) begin
                        guess_d = {guess_q[7:0], digit_in};
                        if (digit_cnt_q != 2'd3) digit_cnt_d = digit_cnt_q + 2'd1;
                    end
                    if (submit_ok) begin
`ifdef DUP_DIGIT_REJECT_EN
                        if (guess_distinct) state_d = CHECK1;
                        else                dup_d   = 1'b1;
`else
                        state_d = CHECK1;
`endif
                    end
                end
                CHECK1: state_d = CHECK2;
                CHECK2: begin
                    last_d  = check_result;
                    tries_d = tries_q + 4'd1;
                    state_d = JUDGE;
                end
                JUDGE: begin
                    if (last_q[5:3] == WIN_CODE) begin
                        state_d = WIN;
                    end else if (tries_q == 4'(MAX_TRIES)) begin
                        state_d = LOSE;
                    end else begin
                        state_d     = ENTRY;
                        digit_cnt_d = '0;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            target_q    <= '0;
            guess_q     <= '0;
            digit_cnt_q <= '0;
            gen_cnt_q   <= '0;
            last_q      <= '0;
            tries_q     <= '0;
`ifdef DUP_DIGIT_REJECT_EN
            dup_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            target_q    <= target_d;
            guess_q     <= guess_d;
            digit_cnt_q <= digit_cnt_d;
            gen_cnt_q   <= gen_cnt_d;
            last_q      <= last_d;
            tries_q     <= tries_d;
`ifdef DUP_DIGIT_REJECT_EN
            dup_q       <= dup_d;
`endif
        end
    end

    // Masked by rst so the strobe drops in the very cycle reset is sampled
    assign start_check   = ((state_q == CHECK1) || (state_q == CHECK2)) && !rst;
    assign busy          = (state_q == GEN) || (state_q == CHECK1)
                        || (state_q == CHECK2) || (state_q == JUDGE);
    assign game_won      = (state_q == WIN);
    assign game_lost     = (state_q == LOSE);
    assign input_number  = guess_q;
    assign target_number = target_q;
    assign last_result   = last_q;
    assign tries_used    = tries_q;
`ifdef DUP_DIGIT_REJECT_EN
    assign dup_err       = dup_q;
`endif

endmodule

// File: tb/tb_guess_game_ctrl.sv
// Directed bench for guess_game_ctrl: table-driven entry vectors plus multi-cycle sequences.
module tb_guess_game_ctrl;

    logic        clk = 1'b0;
    logic        rst, new_game, digit_valid, submit;
    logic [3:0]  digit_in;
    logic [5:0]  check_result;

    logic [11:0] a_in, a_tgt, b_in, b_tgt;
    logic        a_sc, a_won, a_lost, a_busy, b_sc, b_won, b_lost, b_busy;
    logic [5:0]  a_last, b_last;
    logic [3:0]  a_tries, b_tries;
`ifdef DUP_DIGIT_REJECT_EN
    logic        a_dup, b_dup;
`endif

    always #5 clk = ~clk;

    guess_game_ctrl #(.MAX_TRIES(8), .LFSR_SEED(16'hACE1)) dut_a (
        .clk(clk), .rst(rst), .new_game(new_game), .digit_in(digit_in),
        .digit_valid(digit_valid), .submit(submit), .check_result(check_result),
        .input_number(a_in), .target_number(a_tgt), .start_check(a_sc),
        .last_result(a_last), .tries_used(a_tries), .game_won(a_won),
        .game_lost(a_lost), .busy(a_busy)
`ifdef DUP_DIGIT_REJECT_EN
       ,.dup_err(a_dup)
`endif
    );

    guess_game_ctrl #(.MAX_TRIES(2), .LFSR_SEED(16'hACE1)) dut_b (
        .clk(clk), .rst(rst), .new_game(new_game), .digit_in(digit_in),
        .digit_valid(digit_valid), .submit(submit), .check_result(check_result),
        .input_number(b_in), .target_number(b_tgt), .start_check(b_sc),
        .last_result(b_last), .tries_used(b_tries), .game_won(b_won),
        .game_lost(b_lost), .busy(b_busy)
`ifdef DUP_DIGIT_REJECT_EN
       ,.dup_err(b_dup)
`endif
    );

    int unsigned npass = 0;
    int unsigned ntot  = 0;

    task automatic chk(input string name, input int act, input int exp);
        ntot++;
        if (act == exp) npass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enter(input logic [3:0] d);
        digit_valid = 1'b1;
        digit_in    = d;
        tick();
        digit_valid = 1'b0;
        digit_in    = 4'h0;
    endtask

    task automatic pulse_submit();
        submit = 1'b1;
        tick();
        submit = 1'b0;
    endtask

    task automatic start_game();
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("gen_busy", int'(a_busy), 1);
        for (int i = 0; i < 400 && a_busy; i++) tick();
        chk("gen_done", int'(a_busy), 0);
    endtask

    typedef struct {
        logic        dv;
        logic [3:0]  din;
        logic        sub;
        logic [11:0] exp_in;
        logic        exp_sc;
    } vec_t;

    vec_t        tbl[8];
    logic [3:0]  t2, t1, t0;
    logic [11:0] saved;
    int          sc_cnt;
    logic        ok;

    initial begin
        tbl[0] = '{1'b1, 4'h1, 1'b0, 12'h001, 1'b0};
        tbl[1] = '{1'b1, 4'h2, 1'b0, 12'h012, 1'b0};
        tbl[2] = '{1'b0, 4'h0, 1'b1, 12'h012, 1'b0};  // submit with 2 digits
        tbl[3] = '{1'b1, 4'hB, 1'b0, 12'h012, 1'b0};  // non-BCD ignored
        tbl[4] = '{1'b1, 4'h3, 1'b0, 12'h123, 1'b0};
        tbl[5] = '{1'b1, 4'h4, 1'b1, 12'h234, 1'b0};  // submit with digit_valid
        tbl[6] = '{1'b0, 4'h0, 1'b0, 12'h234, 1'b0};
        tbl[7] = '{1'b0, 4'h0, 1'b1, 12'h234, 1'b1};  // accepted submit

        rst = 1'b1; new_game = 1'b0; digit_valid = 1'b0; submit = 1'b0;
        digit_in = 4'h0; check_result = 6'b001010;
        tick(); tick();
        chk("rst_in",    int'(a_in), 0);
        chk("rst_tgt",   int'(a_tgt), 0);
        chk("rst_sc",    int'(a_sc), 0);
        chk("rst_last",  int'(a_last), 0);
        chk("rst_tries", int'(a_tries), 0);
        chk("rst_flags", int'({a_won, a_lost, a_busy}), 0);
        rst = 1'b0;
        tick();
        chk("idle_busy", int'(a_busy), 0);

        start_game();
        t2 = a_tgt[11:8]; t1 = a_tgt[7:4]; t0 = a_tgt[3:0];
        ok = (t2 <= 4'd9) && (t1 <= 4'd9) && (t0 <= 4'd9) && (t2 != t1) && (t2 != t0) && (t1 != t0);
        chk("tgt_valid", int'(ok), 1);
        chk("tgt_same_seed", int'(b_tgt), int'(a_tgt));
        chk("entry_flags", int'({a_won, a_lost, a_sc}), 0);

        for (int i = 0; i < 8; i++) begin
            digit_valid = tbl[i].dv;
            digit_in    = tbl[i].din;
            submit      = tbl[i].sub;
            tick();
            digit_valid = 1'b0; submit = 1'b0; digit_in = 4'h0;
            chk($sformatf("vec%0d_in", i), int'(a_in), int'(tbl[i].exp_in));
            chk($sformatf("vec%0d_sc", i), int'(a_sc), int'(tbl[i].exp_sc));
        end
        tick();
        chk("wrong1_sc_cycle2", int'(a_sc), 1);
        tick();
        chk("wrong1_sc_judge", int'(a_sc), 0);
        chk("wrong1_last", int'(a_last), 6'b001010);
        chk("wrong1_tries", int'(a_tries), 1);
        tick();
        chk("wrong1_back_entry", int'({a_busy, a_won, a_lost}), 0);
        chk("wrong1_in_kept", int'(a_in), 12'h234);

        enter(4'h5); enter(4'h6); enter(4'h7);
        pulse_submit();
        tick(); tick(); tick();
        chk("a_tries2", int'(a_tries), 2);
        chk("a_not_lost", int'(a_lost), 0);
        chk("b_lost", int'(b_lost), 1);
        chk("b_tries2", int'(b_tries), 2);
        enter(4'h8);
        pulse_submit();
        chk("b_lose_in_held", int'(b_in), 12'h567);
        chk("b_lose_sc", int'(b_sc), 0);
        tick();
        chk("b_lose_tries_held", int'(b_tries), 2);
        chk("b_lose_still", int'(b_lost), 1);

        start_game();
        chk("ng_tries_clr", int'(a_tries), 0);
        chk("ng_in_clr", int'(a_in), 0);
        t2 = a_tgt[11:8]; t1 = a_tgt[7:4]; t0 = a_tgt[3:0];
        check_result = 6'b100000;
        enter(t2); enter(t1); enter(t0);
        pulse_submit();
        sc_cnt = 0;
        for (int c = 1; c <= 4; c++) begin
            sc_cnt += int'(a_sc);
            chk($sformatf("win_at_%0d", c), int'(a_won), (c == 4) ? 1 : 0);
            if (c < 4) tick();
        end
        chk("win_sc_cycles", sc_cnt, 2);
        chk("win_tries", int'(a_tries), 1);
        chk("win_last", int'(a_last), 6'b100000);
        saved = a_in;
        enter(4'h1);
        pulse_submit();
        chk("win_in_held", int'(a_in), int'(saved));
        chk("win_held", int'({a_won, a_sc}), 2'b10);

        start_game();
        enter(4'h1); enter(4'h2); enter(4'h3);
        pulse_submit();
        chk("abort_sc_check1", int'(a_sc), 1);
        new_game = 1'b1;
        tick();
        new_game = 1'b0;
        chk("abort_sc", int'(a_sc), 0);
        chk("abort_busy_gen", int'(a_busy), 1);
        chk("abort_tries", int'(a_tries), 0);
        chk("abort_last", int'(a_last), 0);
        for (int i = 0; i < 400 && a_busy; i++) tick();
        chk("abort_gen_done", int'(a_busy), 0);

        check_result = 6'b001010;
        enter(4'h1); enter(4'h1); enter(4'h2);
        chk("dup_in", int'(a_in), 12'h112);
        pulse_submit();
`ifdef DUP_DIGIT_REJECT_EN
        chk("dup_err_hi", int'(a_dup), 1);
        chk("dup_sc", int'(a_sc), 0);
        tick();
        chk("dup_err_lo", int'(a_dup), 0);
        chk("dup_tries", int'(a_tries), 0);
        chk("dup_entry", int'(a_busy), 0);
`else
        chk("dup_checked_sc", int'(a_sc), 1);
        tick(); tick(); tick();
        chk("dup_checked_tries", int'(a_tries), 1);
`endif

        enter(4'h4); enter(4'h5); enter(4'h6);
        pulse_submit();
        tick();
        chk("rstmid_check2_sc", int'(a_sc), 1);
        rst = 1'b1;
        #1;
        chk("rstmid_sc_drop", int'(a_sc), 0);
        tick();
        rst = 1'b0;
        chk("rstmid_tries", int'(a_tries), 0);
        chk("rstmid_last", int'(a_last), 0);
        chk("rstmid_idle", int'({a_busy, a_sc}), 0);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
